// File: rtl/imem_loader.sv
// Instruction RAM with post-reset clear sweep and UART byte-stream loader.
// Fetch is forced to NOP while clearing or loading.
module imem_loader #(
    parameter int               DATA_W    = 16,
    parameter int               ADDR_W    = 10,
    parameter logic [DATA_W-1:0] FILL_WORD = 'hFFFF,
    parameter logic [DATA_W-1:0] NOP_WORD  = 'h6F0F,
    parameter logic [7:0]       SYNC_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       PCAdd_pc,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic [DATA_W-1:0] M_instruction,
    output logic              busy,
    output logic              load_done
);

    localparam int BPW   = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int BW    = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [BW-1:0] LAST = BW'(BPW - 1);

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_ADR_H,
        S_ADR_L,
        S_CNT_H,
        S_CNT_L,
        S_DATA,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_clr_idx;
    logic [ADDR_W-1:0]   r_addr;
    logic [15:0]         r_cnt;
    logic [7:0]          r_hdr;
    logic [DATA_W-1:0]   r_word;
    logic [BW-1:0]       r_bcnt;
    logic                r_busy;
    logic                r_done;
    logic [DATA_W-1:0]   r_instr;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic [15:0]         w_hdr_next;
    logic [DATA_W-1:0]   w_word_next;
    logic                w_pc_ok;
    logic                w_we;
    logic [ADDR_W-1:0]   w_waddr;
    logic [DATA_W-1:0]   w_wdata;

    assign w_hdr_next  = {r_hdr, rx_data};
    assign w_word_next = DATA_W'({r_word, rx_data});
    assign w_pc_ok     = (PCAdd_pc >> ADDR_W) == 16'd0;

    // Single RAM write port shared by the clear sweep and the loader
    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_clr_idx;
        w_wdata = FILL_WORD;
        if (reset) begin
            if (r_state == S_CLEAR) begin
                w_we = 1'b1;
            end else if (r_state == S_DATA && rx_valid && r_bcnt == LAST) begin
                w_we    = 1'b1;
                w_waddr = r_addr;
                w_wdata = w_word_next;
            end
        end
    end

    // RAM array, no reset so it maps onto block memory
    always_ff @(posedge clk) begin
        if (w_we) r_mem[w_waddr] <= w_wdata;
    end

    // Loader FSM: clear sweep, header parse, payload assembly
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_CLEAR;
            r_clr_idx <= '0;
            r_addr    <= '0;
            r_cnt     <= '0;
            r_hdr     <= '0;
            r_word    <= '0;
            r_bcnt    <= '0;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_CLEAR: begin
                    r_clr_idx <= r_clr_idx + 1'b1;
                    if (r_clr_idx == '1) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                S_IDLE: begin
                    if (rx_valid && rx_data == SYNC_BYTE) begin
                        r_state <= S_ADR_H;
                        r_busy  <= 1'b1;
                    end
                end
                S_ADR_H: begin
                    if (rx_valid) begin
                        r_hdr   <= rx_data;
                        r_state <= S_ADR_L;
                    end
                end
                S_ADR_L: begin
                    if (rx_valid) begin
                        r_addr  <= w_hdr_next[ADDR_W-1:0];
                        r_state <= S_CNT_H;
                    end
                end
                S_CNT_H: begin
                    if (rx_valid) begin
                        r_hdr   <= rx_data;
                        r_state <= S_CNT_L;
                    end
                end
                S_CNT_L: begin
                    if (rx_valid) begin
                        r_cnt  <= w_hdr_next;
                        r_bcnt <= '0;
                        if (w_hdr_next == 16'd0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (rx_valid) begin
                        r_word <= w_word_next;
                        if (r_bcnt == LAST) begin
                            r_bcnt <= '0;
                            r_addr <= r_addr + 1'b1;
                            r_cnt  <= r_cnt - 1'b1;
                            if (r_cnt == 16'd1) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end
                        end else begin
                            r_bcnt <= r_bcnt + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_CLEAR;
            endcase
        end
    end

    // Registered fetch: NOP while busy, fill word outside the array
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_instr <= NOP_WORD;
        end else if (r_busy) begin
            r_instr <= NOP_WORD;
        end else if (w_pc_ok) begin
            r_instr <= r_mem[PCAdd_pc[ADDR_W-1:0]];
        end else begin
            r_instr <= FILL_WORD;
        end
    end

    assign M_instruction = r_instr;
    assign busy          = r_busy;
    assign load_done     = r_done;

endmodule
